// File: rtl/tc_pkg.sv
// Shared constants and FSM encoding for the timing-core tick-memory loader.
package tc_pkg;

   localparam int unsigned DATA_W  = 17;
   localparam int unsigned ADDR_W  = 11;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned N_BANKS = 2;

   localparam logic [2:0] MEM0 = 3'd0;
   localparam logic [2:0] MEM1 = 3'd1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FILL,
      ST_ARMED,
      ST_COMMIT
   } state_t;

endpackage

// File: rtl/tick_mem_loader.sv
// Ping-pong tick-memory producer: fills the idle bank from a point stream and
// hands it to the timing core on its update_mem request.
module tick_mem_loader
   import tc_pkg::*;
#(
   parameter int unsigned DATA_W = tc_pkg::DATA_W,
   parameter int unsigned ADDR_W = tc_pkg::ADDR_W,
   parameter int unsigned CNT_W  = tc_pkg::CNT_W
) (
   input  logic              clk_i,
   input  logic              nrst_i,
   input  logic              enable_i,
   input  logic [9:0]        points_per_line_i,
   input  logic [DATA_W-1:0] s_tdata_i,
   input  logic              s_tvalid_i,
   input  logic              s_tlast_i,
   output logic              s_tready_o,
   input  logic              update_mem_i,
   output logic [ADDR_W-1:0] waddr_o,
   output logic [DATA_W-1:0] wdata_o,
   output logic              we_o,
   output logic [2:0]        memory_selector_o,
   output logic              mem_updated_o,
   output logic              busy_o,
   output logic              late_o,
   output logic              framing_err_o,
   output logic              config_err_o,
   output logic [CNT_W-1:0]  commit_cnt_o
);

   state_t              state_q, state_d;
   logic [ADDR_W-2:0]   ppl_q, ppl_d;
   logic [ADDR_W-2:0]   idx_q, idx_d;
   logic                bank_q, bank_d;
   logic                primed_q, primed_d;
   logic                pend_q, pend_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [2:0]          sel_q, sel_d;
   logic                late_q, late_d;
   logic                ferr_q, ferr_d;
   logic                cerr_q, cerr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                hs;
   logic                last_beat;

   assign s_tready_o        = (state_q == ST_FILL);
   assign mem_updated_o     = (state_q == ST_COMMIT);
   assign busy_o            = (state_q != ST_IDLE);
   assign memory_selector_o = (state_q == ST_COMMIT) ? (bank_q ? MEM1 : MEM0) : sel_q;
   assign we_o              = we_q;
   assign waddr_o           = waddr_q;
   assign wdata_o           = wdata_q;
   assign late_o            = late_q;
   assign framing_err_o     = ferr_q;
   assign config_err_o      = cerr_q;
   assign commit_cnt_o      = cnt_q;

   assign hs        = s_tvalid_i & s_tready_o;
   assign last_beat = (idx_q == ppl_q - 1'b1);

   always_comb begin
      state_d  = state_q;
      ppl_d    = ppl_q;
      idx_d    = idx_q;
      bank_d   = bank_q;
      primed_d = primed_q;
      pend_d   = pend_q;
      we_d     = 1'b0;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      sel_d    = sel_q;
      late_d   = late_q;
      ferr_d   = ferr_q;
      cerr_d   = cerr_q;
      cnt_d    = cnt_q;

      if (hs) begin
         we_d    = 1'b1;
         waddr_d = {bank_q, idx_q};
         wdata_d = s_tdata_i;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (enable_i) begin
               if (points_per_line_i == '0) begin
                  cerr_d = 1'b1;
               end else begin
                  ppl_d   = points_per_line_i;
                  idx_d   = '0;
                  state_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            if (update_mem_i && primed_q) begin
               late_d = 1'b1;
               pend_d = 1'b1;
            end
            if (hs) begin
               if (s_tlast_i != last_beat) ferr_d = 1'b1;
               idx_d = idx_q + 1'b1;
               // A request seen on the final beat itself also skips ARMED.
               if (last_beat) begin
                  state_d = (!primed_q || pend_q || update_mem_i) ? ST_COMMIT : ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            if (update_mem_i) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            cnt_d    = cnt_q + 1'b1;
            sel_d    = bank_q ? MEM1 : MEM0;
            primed_d = 1'b1;
            pend_d   = 1'b0;
            bank_d   = ~bank_q;
            if (points_per_line_i == '0) begin
               if (enable_i) cerr_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               ppl_d   = points_per_line_i;
               idx_d   = '0;
               state_d = ST_FILL;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!enable_i) begin
         state_d  = ST_IDLE;
         bank_d   = 1'b0;
         primed_d = 1'b0;
         pend_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_q  <= ST_IDLE;
         ppl_q    <= '0;
         idx_q    <= '0;
         bank_q   <= 1'b0;
         primed_q <= 1'b0;
         pend_q   <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
         sel_q    <= MEM0;
         late_q   <= 1'b0;
         ferr_q   <= 1'b0;
         cerr_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         ppl_q    <= ppl_d;
         idx_q    <= idx_d;
         bank_q   <= bank_d;
         primed_q <= primed_d;
         pend_q   <= pend_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         sel_q    <= sel_d;
         late_q   <= late_d;
         ferr_q   <= ferr_d;
         cerr_q   <= cerr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_tick_mem_loader.sv
// Bench for tick_mem_loader: directed scenarios plus random soak against a
// cycle-level reference model of the loader's fill/commit rules.
module tb_tick_mem_loader;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        enable = 1'b0;
   logic [9:0]  ppl = '0;
   logic [16:0] tdata = '0;
   logic        tvalid = 1'b0;
   logic        tlast = 1'b0;
   logic        tready;
   logic        upd = 1'b0;
   logic [10:0] waddr;
   logic [16:0] wdata;
   logic        we;
   logic [2:0]  sel;
   logic        memupd;
   logic        busy;
   logic        late;
   logic        ferr;
   logic        cerr;
   logic [15:0] cnt;

   tick_mem_loader dut (
      .clk_i(clk), .nrst_i(nrst), .enable_i(enable), .points_per_line_i(ppl),
      .s_tdata_i(tdata), .s_tvalid_i(tvalid), .s_tlast_i(tlast), .s_tready_o(tready),
      .update_mem_i(upd), .waddr_o(waddr), .wdata_o(wdata), .we_o(we),
      .memory_selector_o(sel), .mem_updated_o(memupd), .busy_o(busy), .late_o(late),
      .framing_err_o(ferr), .config_err_o(cerr), .commit_cnt_o(cnt)
   );

   always #5 clk = ~clk;

   localparam int P_IDLE = 0, P_FILL = 1, P_WAIT = 2, P_COMMIT = 3;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: what the loader is doing, in plain integers
   int m_phase, m_lppl, m_idx, m_bank, m_primed, m_pend, m_sel;
   int m_late, m_ferr, m_cerr, m_cnt;
   int exp_we, exp_addr, exp_data;
   int wlog[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_phase = P_IDLE; m_lppl = 0; m_idx = 0; m_bank = 0; m_primed = 0; m_pend = 0;
      m_sel = 0; m_late = 0; m_ferr = 0; m_cerr = 0; m_cnt = 0;
      exp_we = 0; exp_addr = 0; exp_data = 0;
   endtask

   task automatic check_outputs();
      chk("busy", {31'b0, busy}, (m_phase != P_IDLE));
      chk("tready", {31'b0, tready}, (m_phase == P_FILL));
      chk("mem_updated", {31'b0, memupd}, (m_phase == P_COMMIT));
      chk("selector", {29'b0, sel}, (m_phase == P_COMMIT) ? m_bank : m_sel);
      chk("we", {31'b0, we}, exp_we);
      if (exp_we != 0) begin
         chk("waddr", {21'b0, waddr}, exp_addr);
         chk("wdata", {15'b0, wdata}, exp_data);
      end
      chk("late", {31'b0, late}, m_late);
      chk("framing_err", {31'b0, ferr}, m_ferr);
      chk("config_err", {31'b0, cerr}, m_cerr);
      chk("commit_cnt", {16'b0, cnt}, m_cnt % 65536);
      if (we === 1'b1) wlog.push_back(int'(waddr));
   endtask

   task automatic model_step(input int en, input int p, input int v, input int d,
                             input int l, input int u);
      int hs, last;
      hs = (v != 0) && (m_phase == P_FILL);
      exp_we = hs;
      if (hs != 0) begin
         exp_addr = m_bank * 1024 + m_idx;
         exp_data = d;
      end
      case (m_phase)
         P_IDLE: begin
            if (en != 0) begin
               if (p == 0) m_cerr = 1;
               else begin m_lppl = p; m_idx = 0; m_phase = P_FILL; end
            end
         end
         P_FILL: begin
            if (u != 0 && m_primed != 0) begin m_late = 1; m_pend = 1; end
            if (hs != 0) begin
               last = (m_idx == m_lppl - 1);
               if ((l != 0) != (last != 0)) m_ferr = 1;
               m_idx++;
               if (last != 0) m_phase = (m_primed == 0 || m_pend != 0) ? P_COMMIT : P_WAIT;
            end
         end
         P_WAIT: if (u != 0) m_phase = P_COMMIT;
         default: begin
            m_cnt++; m_sel = m_bank; m_primed = 1; m_pend = 0; m_bank = 1 - m_bank;
            if (p == 0) begin
               if (en != 0) m_cerr = 1;
               m_phase = P_IDLE;
            end else begin m_lppl = p; m_idx = 0; m_phase = P_FILL; end
         end
      endcase
      if (en == 0) begin m_phase = P_IDLE; m_bank = 0; m_primed = 0; m_pend = 0; end
   endtask

   task automatic cyc(input int en, input int p, input int v, input int d,
                      input int l, input int u);
      @(negedge clk);
      check_outputs();
      enable = (en != 0); ppl = 10'(p); tvalid = (v != 0); tdata = 17'(d);
      tlast = (l != 0); upd = (u != 0);
      model_step(en, p, v, d, l, u);
   endtask

   task automatic beats(input int n, input int p, input int tlast_at);
      for (int i = 0; i < n; i++) cyc(1, p, 1, int'($urandom_range(0, 131071)), (i == tlast_at), 0);
   endtask

   initial begin
      int base, bad, guard, v;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_we", {31'b0, we}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_cnt", {16'b0, cnt}, 0);
      chk("rst_sel", {29'b0, sel}, 0);
      nrst = 1'b1;

      // prime bank 0
      cyc(1, 4, 0, 0, 0, 0);
      beats(4, 4, 3);
      cyc(1, 4, 0, 0, 0, 0);
      chk("prime_commit", {31'b0, memupd}, 1);
      chk("prime_sel", {29'b0, sel}, 0);
      chk("prime_nwrites", wlog.size(), 4);
      for (int i = 0; i < 4; i++) chk("prime_addr", wlog[i], i);
      beats(4, 4, 3);
      chk("prime_cnt", {16'b0, cnt}, 1);
      cyc(1, 4, 0, 0, 0, 0);
      cyc(1, 4, 0, 0, 0, 0);
      chk("armed_busy", {31'b0, busy}, 1);
      chk("armed_tready", {31'b0, tready}, 0);
      for (int i = 0; i < 4; i++) chk("bank1_addr", wlog[4 + i], 1024 + i);

      // ping-pong commit
      cyc(1, 4, 0, 0, 0, 1);
      cyc(1, 4, 0, 0, 0, 0);
      chk("pp_commit", {31'b0, memupd}, 1);
      chk("pp_sel", {29'b0, sel}, 1);
      // late request during the bank-0 fill
      beats(2, 4, 9);
      chk("pp_cnt", {16'b0, cnt}, 2);
      cyc(1, 4, 0, 0, 0, 1);
      cyc(1, 4, 1, 17'h1abcd, 0, 0);
      cyc(1, 4, 1, 17'h00042, 1, 0);
      cyc(1, 4, 0, 0, 0, 0);
      chk("late_flag", {31'b0, late}, 1);
      chk("late_commit", {31'b0, memupd}, 1);
      for (int i = 0; i < 4; i++) chk("late_addr", wlog[8 + i], i);

      // framing: tlast on beat 2 of 4
      base = wlog.size();
      beats(4, 4, 1);
      cyc(1, 4, 0, 0, 0, 0);
      chk("framing_flag", {31'b0, ferr}, 1);
      chk("framing_len", wlog.size() - base, 4);
      cyc(1, 4, 0, 0, 0, 1);
      cyc(1, 4, 0, 0, 0, 0);

      // abort mid-fill, then re-prime with a long backpressured line
      beats(2, 4, 9);
      cyc(0, 4, 0, 0, 0, 0);
      cyc(0, 4, 0, 0, 0, 0);
      chk("abort_idle", {31'b0, busy}, 0);
      cyc(0, 360, 0, 0, 0, 0);
      cyc(1, 360, 0, 0, 0, 0);
      base = wlog.size();
      guard = 0;
      while (m_phase == P_FILL && guard < 5000) begin
         v = int'($urandom_range(0, 1));
         cyc(1, 360, v, int'($urandom_range(0, 131071)), (m_idx == m_lppl - 1),
             ($urandom_range(0, 19) == 0));
         guard++;
      end
      chk("bp_timeout", (guard < 5000), 1);
      cyc(1, 360, 0, 0, 0, 0);
      chk("bp_reprime", {31'b0, memupd}, 1);
      chk("bp_reprime_sel", {29'b0, sel}, 0);
      chk("bp_len", wlog.size() - base, 360);
      bad = 0;
      for (int k = 0; k < 360 && base + k < wlog.size(); k++) if (wlog[base + k] != k) bad++;
      chk("bp_contig", bad, 0);

      // config error
      cyc(0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("cfg_flag", {31'b0, cerr}, 1);
      chk("cfg_busy", {31'b0, busy}, 0);

      // asynchronous reset mid-fill
      cyc(1, 5, 0, 0, 0, 0);
      beats(2, 5, 9);
      @(negedge clk);
      enable = 1'b0; tvalid = 1'b0; upd = 1'b0; tlast = 1'b0;
      nrst = 1'b0;
      #1;
      chk("arst_busy", {31'b0, busy}, 0);
      chk("arst_we", {31'b0, we}, 0);
      chk("arst_flags", {29'b0, late, ferr, cerr}, 0);
      chk("arst_cnt", {16'b0, cnt}, 0);
      m_reset();
      @(negedge clk);
      nrst = 1'b1;

      // random soak
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 63) != 0),
             ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 6)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 131071)),
             ((m_phase == P_FILL && m_idx == m_lppl - 1) ? 1 : 0) ^ ($urandom_range(0, 31) == 0),
             ($urandom_range(0, 7) == 0));
      end
      cyc(0, 1, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
